systolic_pe_v2: RTL and testbench

Parametrised weight-stationary processing element for the spiking-transformer systolic array. It adds double-buffered weights: a shadow weight loads through a column shift chain while the active weight keeps computing. A per-PE swap promotes the shadow weight to active. It also has a runtime spike mode: a binary spike gates the weight add instead of a full multiply. Tiles of these PEs form the array. A-matrix data flows left to right, partial sums flow top to bottom, and weights shift down the column.

---
 rtl/systolic_pkg.sv | 27 ++
 rtl/pe_mac_unit.sv | 58 +++++
 rtl/systolic_pe_v2.sv | 123 ++++++++++++
 tb/tb_systolic_pe_v2.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array: default widths, spike-mode encoding
// and saturation bound helpers usable for any width/signedness.
package systolic_pkg;

   localparam int unsigned DATA_WIDTH_DEF = 8;
   localparam int unsigned PSUM_WIDTH_DEF = 20;
   localparam int unsigned SAT_MAX_W      = 64;

   typedef enum logic {
      MODE_MAC   = 1'b0,
      MODE_SPIKE = 1'b1
   } pe_mode_e;

   // Bounds are returned wide; callers truncate to their own psum width.
   function automatic logic [SAT_MAX_W-1:0] sat_max(input int unsigned width, input bit is_signed);
      logic [SAT_MAX_W-1:0] one;
      one = 1;
      return is_signed ? ((one << (width - 1)) - one) : ((one << width) - one);
   endfunction

   function automatic logic [SAT_MAX_W-1:0] sat_min(input int unsigned width, input bit is_signed);
      logic [SAT_MAX_W-1:0] one;
      one = 1;
      return is_signed ? ~((one << (width - 1)) - one) : '0;
   endfunction

endpackage

// File: rtl/pe_mac_unit.sv
// Combinational datapath of one PE: operand extension, multiply or spike-gated
// add, psum accumulate, overflow detection and optional saturation.
module pe_mac_unit
   import systolic_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned PSUM_WIDTH = PSUM_WIDTH_DEF,
   parameter bit          SIGNED     = 1'b1,
   parameter bit          SATURATE   = 1'b1
) (
   input  logic                  spike_mode,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic [DATA_WIDTH-1:0] weight,
   input  logic                  psum_valid,
   input  logic [PSUM_WIDTH-1:0] psum,
   output logic [PSUM_WIDTH-1:0] result,
   output logic                  overflow
);

   localparam int unsigned PROD_W = 2 * DATA_WIDTH;
   localparam int unsigned RES_W  = PSUM_WIDTH + 1;
   localparam logic [PSUM_WIDTH-1:0] PSUM_MAX = PSUM_WIDTH'(sat_max(PSUM_WIDTH, SIGNED));
   localparam logic [PSUM_WIDTH-1:0] PSUM_MIN = PSUM_WIDTH'(sat_min(PSUM_WIDTH, SIGNED));

   logic [PROD_W-1:0] din_ext;
   logic [PROD_W-1:0] w_ext;
   logic [PROD_W-1:0] product;
   logic [RES_W-1:0]  prod_ext;
   logic [RES_W-1:0]  wgt_ext;
   logic [RES_W-1:0]  psum_ext;
   logic [RES_W-1:0]  addend;
   logic [RES_W-1:0]  sum;

   always_comb begin
      // Extending to the full product width first makes the low PROD_W bits of a
      // plain multiply correct for both signed and unsigned operands.
      din_ext  = {{DATA_WIDTH{SIGNED & din[DATA_WIDTH-1]}}, din};
      w_ext    = {{DATA_WIDTH{SIGNED & weight[DATA_WIDTH-1]}}, weight};
      product  = din_ext * w_ext;
      prod_ext = {{(RES_W-PROD_W){SIGNED & product[PROD_W-1]}}, product};
      wgt_ext  = {{(RES_W-DATA_WIDTH){SIGNED & weight[DATA_WIDTH-1]}}, weight};
      psum_ext = psum_valid ? {SIGNED & psum[PSUM_WIDTH-1], psum} : '0;

      if (pe_mode_e'(spike_mode) == MODE_SPIKE) begin
         addend = din[0] ? wgt_ext : '0;
      end else begin
         addend = prod_ext;
      end

      sum      = addend + psum_ext;
      overflow = SIGNED ? (sum[RES_W-1] ^ sum[RES_W-2]) : sum[RES_W-1];
      result   = sum[PSUM_WIDTH-1:0];
      if (overflow && SATURATE) begin
         result = (SIGNED && sum[RES_W-1]) ? PSUM_MIN : PSUM_MAX;
      end
   end

endmodule

// File: rtl/systolic_pe_v2.sv
// Weight-stationary PE with double-buffered weights (shadow chain + swap) and
// a runtime spike mode; every output is registered with one-cycle latency.
module systolic_pe_v2
   import systolic_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned PSUM_WIDTH = PSUM_WIDTH_DEF,
   parameter bit          SIGNED     = 1'b1,
   parameter bit          SATURATE   = 1'b1
) (
   input  logic                  s_clk,
   input  logic                  s_rst,
   input  logic                  spike_mode,
   input  logic                  weight_in_valid,
   input  logic [DATA_WIDTH-1:0] weight_in,
   output logic                  weight_out_valid,
   output logic [DATA_WIDTH-1:0] weight_out,
   input  logic                  weight_swap_in,
   output logic                  weight_swap_out,
   input  logic                  in_data_valid,
   input  logic [DATA_WIDTH-1:0] in_raw_data,
   output logic                  out_data_valid,
   output logic [DATA_WIDTH-1:0] out_raw_data,
   input  logic                  in_psum_data_valid,
   input  logic [PSUM_WIDTH-1:0] in_psum_data,
   output logic                  out_psum_data_valid,
   output logic [PSUM_WIDTH-1:0] out_psum_data,
   input  logic                  ovf_clr,
   output logic                  ovf_sticky
);

   logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
   logic [DATA_WIDTH-1:0] active_q, active_d;
   logic [DATA_WIDTH-1:0] weight_out_q, weight_out_d;
   logic                  weight_out_valid_q, weight_out_valid_d;
   logic                  swap_out_q, swap_out_d;
   logic                  out_data_valid_q, out_data_valid_d;
   logic [DATA_WIDTH-1:0] out_raw_q, out_raw_d;
   logic                  out_psum_valid_q, out_psum_valid_d;
   logic [PSUM_WIDTH-1:0] out_psum_q, out_psum_d;
   logic                  ovf_q, ovf_d;

   logic [PSUM_WIDTH-1:0] mac_result;
   logic                  mac_ovf;

   // Compute always sees the active weight from before any same-cycle swap.
   pe_mac_unit #(
      .DATA_WIDTH (DATA_WIDTH),
      .PSUM_WIDTH (PSUM_WIDTH),
      .SIGNED     (SIGNED),
      .SATURATE   (SATURATE)
   ) u_mac (
      .spike_mode (spike_mode),
      .din        (in_raw_data),
      .weight     (active_q),
      .psum_valid (in_psum_data_valid),
      .psum       (in_psum_data),
      .result     (mac_result),
      .overflow   (mac_ovf)
   );

   always_comb begin
      shadow_d           = shadow_q;
      weight_out_d       = weight_out_q;
      weight_out_valid_d = weight_in_valid;
      if (weight_in_valid) begin
         shadow_d     = weight_in;
         weight_out_d = shadow_q;
      end

      active_d   = weight_swap_in ? shadow_q : active_q;
      swap_out_d = weight_swap_in;

      out_data_valid_d = in_data_valid;
      out_raw_d        = in_data_valid ? in_raw_data : out_raw_q;
      out_psum_valid_d = in_data_valid;
      out_psum_d       = in_data_valid ? mac_result : out_psum_q;

      // A fresh overflow beats a simultaneous clear.
      ovf_d = ovf_q;
      if (in_data_valid && mac_ovf) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge s_clk) begin
      if (s_rst) begin
         shadow_q           <= '0;
         active_q           <= '0;
         weight_out_q       <= '0;
         weight_out_valid_q <= 1'b0;
         swap_out_q         <= 1'b0;
         out_data_valid_q   <= 1'b0;
         out_raw_q          <= '0;
         out_psum_valid_q   <= 1'b0;
         out_psum_q         <= '0;
         ovf_q              <= 1'b0;
      end else begin
         shadow_q           <= shadow_d;
         active_q           <= active_d;
         weight_out_q       <= weight_out_d;
         weight_out_valid_q <= weight_out_valid_d;
         swap_out_q         <= swap_out_d;
         out_data_valid_q   <= out_data_valid_d;
         out_raw_q          <= out_raw_d;
         out_psum_valid_q   <= out_psum_valid_d;
         out_psum_q         <= out_psum_d;
         ovf_q              <= ovf_d;
      end
   end

   assign weight_out_valid    = weight_out_valid_q;
   assign weight_out          = weight_out_q;
   assign weight_swap_out     = swap_out_q;
   assign out_data_valid      = out_data_valid_q;
   assign out_raw_data        = out_raw_q;
   assign out_psum_data_valid = out_psum_valid_q;
   assign out_psum_data       = out_psum_q;
   assign ovf_sticky          = ovf_q;

endmodule

// File: tb/tb_systolic_pe_v2.sv
// Bench for systolic_pe_v2: a saturating and a wrapping instance share stimulus;
// a transaction-level model checks every cycle, plus directed tables/sequences.
module tb_systolic_pe_v2;

   localparam int DW = 8;
   localparam int PW = 20;
   localparam longint MAXV = (longint'(1) << (PW - 1)) - 1;
   localparam longint MINV = -(longint'(1) << (PW - 1));

   logic s_clk = 1'b0;
   logic s_rst, spike_mode, weight_in_valid, weight_swap_in;
   logic in_data_valid, in_psum_data_valid, ovf_clr;
   logic [DW-1:0] weight_in, in_raw_data;
   logic [PW-1:0] in_psum_data;

   logic wov_s, swo_s, odv_s, opv_s, ovf_s;
   logic [DW-1:0] wo_s, ord_s;
   logic [PW-1:0] ops_s;
   logic wov_w, swo_w, odv_w, opv_w, ovf_w;
   logic [DW-1:0] wo_w, ord_w;
   logic [PW-1:0] ops_w;

   int n_vec = 0;
   int n_err = 0;

   logic [DW-1:0] m_shadow, m_active;
   logic e_wov, e_swo, e_odv, e_opv, e_ovf;
   logic [DW-1:0] e_wo, e_ord;
   logic [PW-1:0] e_ops_sat, e_ops_wrap;

   typedef struct {
      logic          spk;
      logic [DW-1:0] w;
      logic [DW-1:0] din;
      logic          pv;
      logic [PW-1:0] psum;
      logic [PW-1:0] exp_sat;
      logic [PW-1:0] exp_wrap;
      logic          exp_ovf;
   } vec_t;

   vec_t tbl [9];

   always #5 s_clk = ~s_clk;

   systolic_pe_v2 #(.DATA_WIDTH(DW), .PSUM_WIDTH(PW), .SIGNED(1'b1), .SATURATE(1'b1)) dut_sat (
      .s_clk(s_clk), .s_rst(s_rst), .spike_mode(spike_mode),
      .weight_in_valid(weight_in_valid), .weight_in(weight_in),
      .weight_out_valid(wov_s), .weight_out(wo_s),
      .weight_swap_in(weight_swap_in), .weight_swap_out(swo_s),
      .in_data_valid(in_data_valid), .in_raw_data(in_raw_data),
      .out_data_valid(odv_s), .out_raw_data(ord_s),
      .in_psum_data_valid(in_psum_data_valid), .in_psum_data(in_psum_data),
      .out_psum_data_valid(opv_s), .out_psum_data(ops_s),
      .ovf_clr(ovf_clr), .ovf_sticky(ovf_s)
   );

   systolic_pe_v2 #(.DATA_WIDTH(DW), .PSUM_WIDTH(PW), .SIGNED(1'b1), .SATURATE(1'b0)) dut_wrap (
      .s_clk(s_clk), .s_rst(s_rst), .spike_mode(spike_mode),
      .weight_in_valid(weight_in_valid), .weight_in(weight_in),
      .weight_out_valid(wov_w), .weight_out(wo_w),
      .weight_swap_in(weight_swap_in), .weight_swap_out(swo_w),
      .in_data_valid(in_data_valid), .in_raw_data(in_raw_data),
      .out_data_valid(odv_w), .out_raw_data(ord_w),
      .in_psum_data_valid(in_psum_data_valid), .in_psum_data(in_psum_data),
      .out_psum_data_valid(opv_w), .out_psum_data(ops_w),
      .ovf_clr(ovf_clr), .ovf_sticky(ovf_w)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference arithmetic on plain integers, independent of bit-level structure.
   function automatic void ref_op(input logic [DW-1:0] din, input logic [DW-1:0] w,
                                  input logic [PW-1:0] psum, input logic pv, input logic spk,
                                  output logic [PW-1:0] sat_v, output logic [PW-1:0] wrap_v,
                                  output logic ovf);
      longint p, a, s;
      p = pv ? longint'($signed(psum)) : 64'sd0;
      if (spk) a = din[0] ? longint'($signed(w)) : 64'sd0;
      else     a = longint'($signed(din)) * longint'($signed(w));
      s = p + a;
      ovf    = (s > MAXV) || (s < MINV);
      wrap_v = s[PW-1:0];
      if (s > MAXV)      sat_v = 20'h7FFFF;
      else if (s < MINV) sat_v = 20'h80000;
      else               sat_v = s[PW-1:0];
   endfunction

   task automatic idle();
      spike_mode = 1'b0; weight_in_valid = 1'b0; weight_in = '0; weight_swap_in = 1'b0;
      in_data_valid = 1'b0; in_raw_data = '0; in_psum_data_valid = 1'b0;
      in_psum_data = '0; ovf_clr = 1'b0;
   endtask

   task automatic tick();
      logic [PW-1:0] sv, wv;
      logic ov;
      ref_op(in_raw_data, m_active, in_psum_data, in_psum_data_valid, spike_mode, sv, wv, ov);
      @(posedge s_clk);
      #1;
      if (s_rst) begin
         m_shadow = '0; m_active = '0;
         e_wov = 0; e_wo = '0; e_swo = 0; e_odv = 0; e_ord = '0;
         e_opv = 0; e_ops_sat = '0; e_ops_wrap = '0; e_ovf = 0;
      end else begin
         e_odv = in_data_valid;
         e_opv = in_data_valid;
         if (in_data_valid) begin
            e_ord = in_raw_data; e_ops_sat = sv; e_ops_wrap = wv;
         end
         if (in_data_valid && ov) e_ovf = 1'b1;
         else if (ovf_clr)        e_ovf = 1'b0;
         e_swo = weight_swap_in;
         if (weight_swap_in) m_active = m_shadow;
         if (weight_in_valid) begin
            e_wo = m_shadow; m_shadow = weight_in;
         end
         e_wov = weight_in_valid;
      end
      chk("weight_out_valid", wov_s, e_wov);
      chk("weight_out", wo_s, e_wo);
      chk("weight_swap_out", swo_s, e_swo);
      chk("out_data_valid", odv_s, e_odv);
      chk("out_raw_data", ord_s, e_ord);
      chk("out_psum_valid", opv_s, e_opv);
      chk("out_psum_sat", ops_s, e_ops_sat);
      chk("ovf_sticky_sat", ovf_s, e_ovf);
      chk("out_psum_valid_wrap", opv_w, e_opv);
      chk("out_psum_wrap", ops_w, e_ops_wrap);
      chk("ovf_sticky_wrap", ovf_w, e_ovf);
   endtask

   task automatic load_active(input logic [DW-1:0] w);
      idle(); weight_in_valid = 1'b1; weight_in = w; tick();
      idle(); weight_swap_in = 1'b1; tick();
      idle();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0] = '{1'b0, 8'hFD, 8'd5,   1'b1, 20'd100,    20'd85,     20'd85,     1'b0};
      tbl[1] = '{1'b1, 8'd12, 8'h01,  1'b1, 20'd40,     20'd52,     20'd52,     1'b0};
      tbl[2] = '{1'b1, 8'd12, 8'hFE,  1'b1, 20'd40,     20'd40,     20'd40,     1'b0};
      tbl[3] = '{1'b1, 8'd12, 8'h01,  1'b0, 20'd40,     20'd12,     20'd12,     1'b0};
      tbl[4] = '{1'b0, 8'd127, 8'd127, 1'b1, 20'h7FFFF, 20'h7FFFF,  20'h83F00,  1'b1};
      tbl[5] = '{1'b0, 8'h80, 8'h80,  1'b1, 20'd0,      20'h04000,  20'h04000,  1'b0};
      tbl[6] = '{1'b0, 8'h80, 8'd127, 1'b1, 20'h80000,  20'h80000,  20'h7C080,  1'b1};
      tbl[7] = '{1'b1, 8'hFB, 8'h03,  1'b1, 20'd10,     20'd5,      20'd5,      1'b0};
      tbl[8] = '{1'b0, 8'd7,  8'd0,   1'b1, 20'h12345,  20'h12345,  20'h12345,  1'b0};

      // Reset then idle.
      idle(); s_rst = 1'b1; tick();
      s_rst = 1'b0; tick(); tick();
      chk("reset_psum", ops_s, 20'd0);
      $display("reset/idle: psum=0x%0h ovf=%0b", ops_s, ovf_s);

      // Shadow chain 7,8,9 with swap on the last beat.
      idle(); weight_in_valid = 1'b1; weight_in = 8'd7; tick();
      chk("chain_beat0", wo_s, 8'd0);
      weight_in = 8'd8; tick();
      chk("chain_beat1", wo_s, 8'd7);
      weight_in = 8'd9; weight_swap_in = 1'b1; tick();
      chk("chain_beat2", wo_s, 8'd8);
      idle(); in_data_valid = 1'b1; in_raw_data = 8'd1; tick();
      chk("chain_active", ops_s, 20'd8);
      $display("shadow chain: weight_out=0x%0h active probe psum=0x%0h", wo_s, ops_s);

      // Directed table.
      for (int i = 0; i < 9; i++) begin
         load_active(tbl[i].w);
         ovf_clr = 1'b1; tick();
         idle();
         spike_mode = tbl[i].spk; in_data_valid = 1'b1; in_raw_data = tbl[i].din;
         in_psum_data_valid = tbl[i].pv; in_psum_data = tbl[i].psum;
         tick();
         chk("tbl_psum_sat", ops_s, tbl[i].exp_sat);
         chk("tbl_psum_wrap", ops_w, tbl[i].exp_wrap);
         chk("tbl_ovf", ovf_s, tbl[i].exp_ovf);
         chk("tbl_raw", ord_s, tbl[i].din);
         $display("vec %0d: spk=%0b w=0x%0h din=0x%0h psum=0x%0h -> sat=0x%0h wrap=0x%0h ovf=%0b",
                  i, tbl[i].spk, tbl[i].w, tbl[i].din, tbl[i].psum, ops_s, ops_w, ovf_s);
         idle();
      end

      // Swap in the middle of a data stream: active 2, shadow 4.
      load_active(8'd2);
      weight_in_valid = 1'b1; weight_in = 8'd4; tick();
      idle(); in_data_valid = 1'b1; in_raw_data = 8'd1; tick();
      weight_swap_in = 1'b1; tick();
      chk("stream_pre_swap", ops_s, 20'd2);
      chk("stream_swap_out", swo_s, 1'b1);
      weight_swap_in = 1'b0; tick();
      chk("stream_post_swap", ops_s, 20'd4);
      chk("stream_swap_out_end", swo_s, 1'b0);
      $display("swap in stream: psum after swap=0x%0h", ops_s);

      // New overflow coinciding with ovf_clr keeps the sticky bit set.
      load_active(8'd127);
      in_data_valid = 1'b1; in_raw_data = 8'd127; in_psum_data_valid = 1'b1;
      in_psum_data = 20'h7FFFF; ovf_clr = 1'b1; tick();
      chk("ovf_clr_collide", ovf_s, 1'b1);
      idle(); ovf_clr = 1'b1; tick();
      chk("ovf_clr", ovf_s, 1'b0);
      $display("ovf clear: sticky=%0b", ovf_s);

      // Reset in the middle of a MAC stream.
      idle(); in_data_valid = 1'b1; in_raw_data = 8'd9; in_psum_data_valid = 1'b1;
      in_psum_data = 20'd55; tick();
      s_rst = 1'b1; tick();
      chk("midrst_psum", ops_s, 20'd0);
      chk("midrst_valid", opv_s, 1'b0);
      chk("midrst_raw", ord_s, 8'd0);
      s_rst = 1'b0; idle(); tick();
      $display("mid-stream reset: psum=0x%0h valid=%0b", ops_s, opv_s);

      // Randomized traffic against the model.
      for (int c = 0; c < 400; c++) begin
         s_rst              = ($urandom_range(63) == 0);
         spike_mode         = 1'($urandom_range(1));
         weight_in_valid    = 1'($urandom_range(1));
         weight_in          = 8'($urandom);
         weight_swap_in     = ($urandom_range(3) == 0);
         in_data_valid      = ($urandom_range(3) != 0);
         in_raw_data        = 8'($urandom);
         in_psum_data_valid = ($urandom_range(3) != 0);
         in_psum_data       = 20'($urandom);
         ovf_clr            = ($urandom_range(7) == 0);
         tick();
      end
      idle(); s_rst = 1'b0; tick();
      $display("random phase: 400 cycles");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
